regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count; ADDR_W = clog2(NREG) (default 5).
REQ-003 SHALL have parameter NWR, default 2, number of write ports; NRD, default 4, number of read ports.
REQ-004 SHALL have parameter CNT_W, default 2, width of the per-register pending-writer counter; CNT_MAX = 2^CNT_W-1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 we  in  NWR  per-port write enable.
REQ-008 waddr  in  NWR*ADDR_W  write addresses; port k in slice k.
REQ-009 wdata  in  NWR*DATA_W  write data; port k in slice k.
REQ-010 alloc  in  NWR  per-port pending-writer allocation strobe.
REQ-011 alloc_addr  in  NWR*ADDR_W  destination register being allocated.
REQ-012 flush  in  1  clears all pending counters.
REQ-013 raddr  in  NRD*ADDR_W  read addresses.
REQ-014 rdata  out  NRD*DATA_W  combinational read data with write bypass.
REQ-015 rbusy  out  NRD  combinational: read register still has pending writers after this cycle's writebacks.
REQ-016 ovf  out  1  sticky pending-counter overflow flag.

Function
REQ-017 Register 0 SHALL be hardwired zero: writes and allocs to it ignored; reads return 0; rbusy for it always 0.
REQ-018 Storage SHALL update on clk rising edge for every port with we=1 and waddr!=0.
REQ-019 Same-cycle writes to one address SHALL resolve highest port index wins; no other register affected.
REQ-020 rdata[i] SHALL be: 0 if areset or raddr[i]==0; else wdata of highest-index port with we=1 and waddr==raddr[i]; else stored value.
REQ-021 Read path SHALL be purely combinational (zero-cycle latency); write visible in storage next cycle.
REQ-022 Per register r: a = count of alloc ports with alloc_addr==r; d = count of we ports with waddr==r.
REQ-023 Next count SHALL be cnt - min(d,cnt) + a; writes to a register with count 0 SHALL still update data, not underflow.
REQ-024 If next count exceeds CNT_MAX, count SHALL saturate at CNT_MAX and ovf SHALL set and stay 1 until reset.
REQ-025 flush=1 SHALL force every count to the same-cycle a (allocs in flush cycle survive, prior pending discarded); same-cycle writes still update data.
REQ-026 rbusy[i] SHALL equal (cnt[raddr[i]] - min(d,cnt[raddr[i]])) != 0, ignoring same-cycle alloc and flush.
REQ-027 NREG not a power of two: addresses >= NREG SHALL be ignored for write/alloc and read as 0, not busy.
REQ-028 No internal FSM beyond counters; block accepts every request every cycle, no backpressure.

Reset
REQ-029 areset asserted SHALL immediately (asynchronously) clear all counts to 0 and ovf to 0, and force rdata=0, rbusy=0.
REQ-030 Storage array SHALL NOT be reset; contents undefined until written.
REQ-031 areset assertion mid-operation SHALL discard same-edge writes/allocs; first edge after deassertion SHALL operate normally.

Verification
REQ-032 Write r5=0x1234 via port0; same cycle raddr0=5 -> rdata0=0x1234 (bypass); next cycle still 0x1234 from storage.
REQ-033 Port0 and port1 both write r7 (0xA, 0xB) -> rdata=0xB same cycle and thereafter; r0 write 0xFF -> reads 0.
REQ-034 Alloc r3 twice over two cycles -> rbusy=1; one writeback -> rbusy=1; second writeback -> rbusy=0 during that cycle, count 0 after.
REQ-035 Alloc r4 CNT_MAX+1 times without writeback -> count holds 3, ovf=1 and sticky through later writebacks.
REQ-036 Alloc r2 and r9 pending, then flush with alloc r9 same cycle -> next cycle r2 not busy, r9 busy with count 1.
REQ-037 areset pulse asserted between edges with pending counts and ovf=1 -> rbusy, ovf, rdata drop to 0 immediately; r5 retains 0x1234 after release.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-ported register file: write/alloc/flush requests
// in, bypassed read data, busy flags and the overflow flag out.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NWR    = 2,
  parameter int unsigned NRD    = 4,
  parameter int unsigned ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NWR-1:0]        alloc;
  logic [NWR*ADDR_W-1:0] alloc_addr;
  logic                  flush;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  ovf;

  modport master (
    output we, waddr, wdata, alloc, alloc_addr, flush, raddr,
    input  rdata, rbusy, ovf
  );

  modport slave (
    input  we, waddr, wdata, alloc, alloc_addr, flush, raddr,
    output rdata, rbusy, ovf
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with write bypass and per-register pending-writer
// counters (scoreboard) that report busy registers and a sticky overflow.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NWR    = 2,
  parameter int unsigned NRD    = 4,
  parameter int unsigned CNT_W  = 2
) (
  input logic         clk,
  input logic         areset,
  regfile_mp_if.slave bus
);
  localparam int unsigned ADDR_W  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [CNT_W-1:0]  rem   [NREG];
  logic              ovf_q, ovf_d;

  // Register 0 never counts allocs, so its count (and rem) stays zero.
  always_comb begin
    int unsigned a_n, d_n, c, nxt;
    a_n   = 0;
    d_n   = 0;
    c     = 0;
    nxt   = 0;
    ovf_d = ovf_q;
    for (int r = 0; r < NREG; r++) begin
      a_n = 0;
      d_n = 0;
      for (int k = 0; k < NWR; k++) begin
        if (r != 0 && bus.alloc[k] && bus.alloc_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          a_n = a_n + 1;
        end
        if (bus.we[k] && bus.waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          d_n = d_n + 1;
        end
      end
      c      = 32'(cnt_q[r]);
      c      = c - ((d_n < c) ? d_n : c);
      rem[r] = CNT_W'(c);
      nxt    = bus.flush ? a_n : c + a_n;
      if (nxt > CNT_MAX) begin
        nxt   = CNT_MAX;
        ovf_d = 1'b1;
      end
      cnt_d[r] = CNT_W'(nxt);
    end
  end

  // Storage shares the reset process only so reset-edge writes are dropped;
  // the array itself is intentionally never cleared.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      ovf_q <= ovf_d;
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && bus.waddr[k*ADDR_W +: ADDR_W] != '0 &&
            32'(bus.waddr[k*ADDR_W +: ADDR_W]) < NREG) begin
          mem_q[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.raddr[i*ADDR_W +: ADDR_W];
      if (!areset && ra != '0 && 32'(ra) < NREG) begin
        bus.rdata[i*DATA_W +: DATA_W] = mem_q[ra];
        // Ascending scan lets the highest matching port win.
        for (int k = 0; k < NWR; k++) begin
          if (bus.we[k] && bus.waddr[k*ADDR_W +: ADDR_W] == ra) begin
            bus.rdata[i*DATA_W +: DATA_W] = bus.wdata[k*DATA_W +: DATA_W];
          end
        end
        bus.rbusy[i] = (rem[ra] != '0);
      end
    end
  end

  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array/count model.
module tb_regfile_mp;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned NWR     = 2;
  localparam int unsigned NRD     = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int          CNT_MAX = 3;

  logic clk = 1'b0;
  logic areset;

  regfile_mp_if #(.DATA_W(DATA_W), .NREG(NREG), .NWR(NWR), .NRD(NRD), .ADDR_W(ADDR_W)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .NREG(NREG), .NWR(NWR), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] m_mem [NREG];
  int                m_cnt [NREG];
  bit                m_ovf;
  int                checks = 0;
  int                errors = 0;

  function automatic int wa(int k);
    return int'(bus.waddr[k*ADDR_W +: ADDR_W]);
  endfunction

  function automatic int aa(int k);
    return int'(bus.alloc_addr[k*ADDR_W +: ADDR_W]);
  endfunction

  task automatic drv_idle();
    bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.alloc = '0; bus.alloc_addr = '0; bus.flush = 1'b0; bus.raddr = '0;
  endtask

  task automatic set_wr(int k, int a, logic [DATA_W-1:0] d);
    bus.we[k] = 1'b1;
    bus.waddr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_alloc(int k, int a);
    bus.alloc[k] = 1'b1;
    bus.alloc_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_rd(int i, int a);
    bus.raddr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  // Expected outputs derived from the model for the inputs currently driven.
  task automatic check_all(string tag);
    for (int i = 0; i < NRD; i++) begin
      int ra, d, pend;
      logic [DATA_W-1:0] exp_d;
      logic exp_b;
      ra = int'(bus.raddr[i*ADDR_W +: ADDR_W]);
      exp_d = '0;
      exp_b = 1'b0;
      if (!areset && ra != 0) begin
        bit found;
        found = 0;
        exp_d = m_mem[ra];
        d = 0;
        for (int k = NWR - 1; k >= 0; k--) begin
          if (bus.we[k] && wa(k) == ra) begin
            d++;
            if (!found) begin
              exp_d = bus.wdata[k*DATA_W +: DATA_W];
              found = 1;
            end
          end
        end
        pend  = m_cnt[ra] - ((d < m_cnt[ra]) ? d : m_cnt[ra]);
        exp_b = (pend != 0);
      end
      checks++;
      assert (bus.rdata[i*DATA_W +: DATA_W] === exp_d) else begin
        errors++;
        $error("FAIL %s rdata[%0d] got %h expected %h", tag, i,
               bus.rdata[i*DATA_W +: DATA_W], exp_d);
      end
      checks++;
      assert (bus.rbusy[i] === exp_b) else begin
        errors++;
        $error("FAIL %s rbusy[%0d] got %b expected %b", tag, i, bus.rbusy[i], exp_b);
      end
    end
    checks++;
    assert (bus.ovf === (m_ovf && !areset)) else begin
      errors++;
      $error("FAIL %s ovf got %b expected %b", tag, bus.ovf, m_ovf && !areset);
    end
  endtask

  task automatic model_step();
    int nc [NREG];
    if (areset) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_ovf = 0;
      return;
    end
    for (int r = 0; r < NREG; r++) begin
      int a, d, left;
      a = 0;
      d = 0;
      for (int k = 0; k < NWR; k++) begin
        if (r != 0 && bus.alloc[k] && aa(k) == r) a++;
        if (bus.we[k] && wa(k) == r) d++;
      end
      left  = m_cnt[r] - ((d < m_cnt[r]) ? d : m_cnt[r]);
      nc[r] = bus.flush ? a : left + a;
      if (nc[r] > CNT_MAX) begin
        nc[r] = CNT_MAX;
        m_ovf = 1;
      end
    end
    for (int r = 0; r < NREG; r++) m_cnt[r] = nc[r];
    for (int k = 0; k < NWR; k++) begin
      if (bus.we[k] && wa(k) != 0) m_mem[wa(k)] = bus.wdata[k*DATA_W +: DATA_W];
    end
  endtask

  task automatic step(string tag);
    #1;
    check_all(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv_idle();
    areset = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      m_cnt[r] = 0;
      m_mem[r] = '0;
    end
    m_ovf = 0;
    step("reset");
    areset = 1'b0;

    // Give every register a defined value before any random reads.
    for (int r = 1; r < NREG; r += 2) begin
      drv_idle();
      set_wr(0, r, $urandom);
      if (r + 1 < NREG) set_wr(1, r + 1, $urandom);
      step("init");
    end

    drv_idle(); set_wr(0, 5, 32'h1234); set_rd(0, 5); step("bypass_r5");
    drv_idle(); set_rd(0, 5); step("stored_r5");

    drv_idle(); set_wr(0, 7, 32'hA); set_wr(1, 7, 32'hB); set_rd(0, 7); step("dual_wr_r7");
    drv_idle(); set_rd(0, 7); step("r7_after");
    drv_idle(); set_wr(0, 0, 32'hFF); set_rd(1, 0); step("r0_write");
    drv_idle(); set_rd(1, 0); step("r0_read");

    drv_idle(); set_alloc(0, 3); set_rd(0, 3); step("alloc_r3_a");
    drv_idle(); set_alloc(1, 3); set_rd(0, 3); step("alloc_r3_b");
    drv_idle(); set_rd(0, 3); step("r3_busy");
    drv_idle(); set_wr(0, 3, 32'h33); set_rd(0, 3); step("r3_wb1");
    drv_idle(); set_wr(1, 3, 32'h34); set_rd(0, 3); step("r3_wb2");
    drv_idle(); set_rd(0, 3); step("r3_idle");

    for (int n = 0; n <= CNT_MAX; n++) begin
      drv_idle(); set_alloc(0, 4); set_rd(0, 4); step("alloc_r4");
    end
    for (int n = 0; n < 4; n++) begin
      drv_idle(); set_wr(0, 4, $urandom); set_rd(0, 4); step("r4_wb");
    end

    drv_idle(); set_alloc(0, 2); set_alloc(1, 9); step("alloc_r2_r9");
    drv_idle(); bus.flush = 1'b1; set_alloc(0, 9); set_rd(0, 2); set_rd(1, 9); step("flush");
    drv_idle(); set_rd(0, 2); set_rd(1, 9); step("post_flush");
    drv_idle(); set_wr(0, 9, 32'h99); set_rd(1, 9); step("r9_wb");

    drv_idle(); set_alloc(0, 6); step("alloc_r6");
    drv_idle(); set_rd(0, 5); set_rd(1, 6); step("pre_reset");
    areset = 1'b1;
    drv_idle(); set_wr(0, 5, 32'hDEAD); set_alloc(0, 6); set_rd(0, 5); set_rd(1, 6);
    step("in_reset");
    areset = 1'b0;
    drv_idle(); set_rd(0, 5); set_rd(1, 6); step("after_reset");
    checks++;
    assert (bus.rdata[DATA_W-1:0] === 32'h1234) else begin
      errors++;
      $error("FAIL r5_retained got %h expected %h", bus.rdata[DATA_W-1:0], 32'h1234);
    end

    for (int n = 0; n < 600; n++) begin
      drv_idle();
      areset = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NWR; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                 $urandom);
        if ($urandom_range(0, 9) < 4) set_alloc(k, $urandom_range(0, 7));
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NRD; i++)
        set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      step("random");
      areset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
